// File: rtl/clk_rate_pkg.sv
// Shared encodings and defaults for the programmable CPU slow-clock generator.
package clk_rate_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } rate_state_e;

  // Entry i sits at bits [i*32 +: 32]; entry 0 is the fastest rate.
  localparam logic [4*32-1:0] DEF_DIV_TABLE = {32'd10000000, 32'd1000000, 32'd100000, 32'd10000};

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_rate_gen_rise_detect.sv
// Registered-history rising-edge detector for the debounced step button.
module rise_detect (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (clr) prev_q <= 1'b0;
    else     prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/clk_rate_gen.sv
// Programmable CPU clock divider with run/pause/single-step control.
// Define CLK_RATE_CYCLE_CNT_EN to build the CPU clock counter on cycle_cnt.
module clk_rate_gen
  import clk_rate_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int NUM_RATES = 4,
  parameter int SEL_W     = sel_w(NUM_RATES),
  parameter logic [NUM_RATES*CNT_W-1:0] DIV_TABLE = DEF_DIV_TABLE
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [SEL_W-1:0] rate_sel,
  input  logic             run_en,
  input  logic             step_req,
  output logic             clk_n,
  output logic             tick,
  output logic             busy,
  output logic [31:0]      cycle_cnt
);

  rate_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, act_h_q, act_h_d, sel_h;
  logic             clk_n_q, clk_n_d, tick_q, tick_d;
  logic             step_rise, end_half;

  rise_detect u_step (.clk(clk), .clr(clr), .d(step_req), .rise(step_rise));

  // Out-of-range selects fall through to the last entry; a zero divisor acts as 1.
  always_comb begin
    sel_h = DIV_TABLE[(NUM_RATES-1)*CNT_W +: CNT_W];
    for (int i = 0; i < NUM_RATES; i++)
      if (int'(rate_sel) == i) sel_h = DIV_TABLE[i*CNT_W +: CNT_W];
    if (sel_h == '0) sel_h = CNT_W'(1);
  end

  assign end_half = (cnt_q == act_h_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_h_d = act_h_q;
    clk_n_d = clk_n_q;
    tick_d  = 1'b0;
    case (state_q)
      HOLD: begin
        cnt_d   = '0;
        clk_n_d = 1'b0;
        if (run_en || step_rise) begin
          state_d = run_en ? RUN : STEP;
          clk_n_d = 1'b1;
          tick_d  = 1'b1;
          act_h_d = sel_h;
        end
      end
      RUN, STEP: begin
        if (!end_half) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (clk_n_q) begin
            clk_n_d = 1'b0;
          end else if (state_q == RUN && run_en) begin
            // Back-to-back period: the new rate is latched only here.
            clk_n_d = 1'b1;
            tick_d  = 1'b1;
            act_h_d = sel_h;
          end else begin
            state_d = HOLD;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      act_h_q <= CNT_W'(1);
      clk_n_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_h_q <= act_h_d;
      clk_n_q <= clk_n_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_n = clk_n_q;
  assign tick  = tick_q;
  assign busy  = (state_q != HOLD);

`ifdef CLK_RATE_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (clr)         cyc_q <= '0;
    else if (tick_d) cyc_q <= cyc_q + 32'd1;
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_rate_gen.sv
// Scoreboard bench for clk_rate_gen: expected per-cycle outputs are queued with stimulus.
module tb_clk_rate_gen;

  localparam logic [127:0] TABLE = {32'd0, 32'd1, 32'd2, 32'd4};

  logic        clk = 1'b0;
  logic        clr, run_en, step_req;
  logic [1:0]  rate_sel;
  logic        clk_n, tick, busy;
  logic [31:0] cycle_cnt;

  typedef struct packed {
    logic        clk_n;
    logic        tick;
    logic        busy;
    logic [31:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        e;
  logic [31:0] exp_cnt;
  int          errs = 0;
  int          checks = 0;

  clk_rate_gen #(.CNT_W(32), .NUM_RATES(4), .SEL_W(2), .DIV_TABLE(TABLE)) dut (
    .clk(clk), .clr(clr), .rate_sel(rate_sel), .run_en(run_en), .step_req(step_req),
    .clk_n(clk_n), .tick(tick), .busy(busy), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t cur();
    return '{clk_n, tick, busy, cycle_cnt};
  endfunction

  task automatic push(input logic c, input logic t, input logic b);
    obs_t x;
`ifdef CLK_RATE_CYCLE_CNT_EN
    if (t) exp_cnt = exp_cnt + 32'd1;
`endif
    x = '{c, t, b, exp_cnt};
    exp_q.push_back(x);
  endtask

  task automatic push_period(input int h);
    for (int i = 0; i < h; i++) push(1'b1, i == 0, 1'b1);
    for (int i = 0; i < h; i++) push(1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_hold(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    clr = 1'b1; run_en = 1'b0; step_req = 1'b0; rate_sel = 2'd0; exp_cnt = '0;
    cyc(); cyc();
    checks++; if (clk_n !== 1'b0) begin errs++; $display("FAIL reset clk_n got %b exp 0", clk_n); end
    checks++; if (tick !== 1'b0) begin errs++; $display("FAIL reset tick got %b exp 0", tick); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy got %b exp 0", busy); end
    checks++; if (cycle_cnt !== 32'd0) begin errs++; $display("FAIL reset cycle_cnt got %0d exp 0", cycle_cnt); end
    clr = 1'b0;
    cyc();
  endtask

  task automatic test_run();
    run_en = 1'b1;
    repeat (3) push_period(4);
    for (int i = 0; i < 24; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (cur() !== e) begin errs++; $display("FAIL run cyc%0d got %h exp %h", i, cur(), e); end
    end
  endtask

  task automatic test_rate_change();
    push_period(4); push_period(2); push_period(2);
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 1) rate_sel = 2'd1;
      e = exp_q.pop_front();
      checks++;
      if (cur() !== e) begin errs++; $display("FAIL rate_change cyc%0d got %h exp %h", i, cur(), e); end
    end
  endtask

  task automatic test_min_rate();
    rate_sel = 2'd2;
    repeat (6) push_period(1);
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 5) rate_sel = 2'd3;
      e = exp_q.pop_front();
      checks++;
      if (cur() !== e) begin errs++; $display("FAIL min_rate cyc%0d got %h exp %h", i, cur(), e); end
    end
  endtask

  task automatic test_pause();
    rate_sel = 2'd0;
    push_period(4); push_hold(4);
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 1) run_en = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (cur() !== e) begin errs++; $display("FAIL pause cyc%0d got %h exp %h", i, cur(), e); end
    end
  endtask

  task automatic test_step();
    rate_sel = 2'd1;
    for (int s = 0; s < 3; s++) begin
      step_req = 1'b1;
      push_period(2); push_hold(6);
      for (int i = 0; i < 10; i++) begin
        cyc();
        if (i == 1) step_req = 1'b0;
        if (s == 2 && i == 2) step_req = 1'b1;
        if (s == 2 && i == 5) step_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (cur() !== e) begin errs++; $display("FAIL step%0d cyc%0d got %h exp %h", s, i, cur(), e); end
      end
    end
  endtask

  task automatic test_priority();
    rate_sel = 2'd2;
    run_en = 1'b1; step_req = 1'b1;
    push_period(1); push_period(1); push_hold(3);
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (i == 2) begin run_en = 1'b0; step_req = 1'b0; end
      e = exp_q.pop_front();
      checks++;
      if (cur() !== e) begin errs++; $display("FAIL priority cyc%0d got %h exp %h", i, cur(), e); end
    end
  endtask

  task automatic test_clr_mid();
    rate_sel = 2'd0; run_en = 1'b1;
    push(1'b1, 1'b1, 1'b1); push(1'b1, 1'b0, 1'b1); push(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (cur() !== e) begin errs++; $display("FAIL clr_mid pre cyc%0d got %h exp %h", i, cur(), e); end
    end
    clr = 1'b1;
    cyc();
    checks++; if (clk_n !== 1'b0) begin errs++; $display("FAIL clr_mid clk_n got %b exp 0", clk_n); end
    checks++; if (tick !== 1'b0) begin errs++; $display("FAIL clr_mid tick got %b exp 0", tick); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL clr_mid busy got %b exp 0", busy); end
    checks++; if (cycle_cnt !== 32'd0) begin errs++; $display("FAIL clr_mid cycle_cnt got %0d exp 0", cycle_cnt); end
    clr = 1'b0; run_en = 1'b0; exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({clk_n, busy, cycle_cnt} !== {1'b0, 1'b0, 32'd0})
        begin errs++; $display("FAIL clr_mid hold cyc%0d got %b/%b/%0d exp 0/0/0", i, clk_n, busy, cycle_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_rate_change();
    test_min_rate();
    test_pause();
    test_step();
    test_priority();
    test_clr_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
